// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI flash command sequencer: flash opcodes,
// host command encoding and the sequencer state enumeration.
package spi_seq_pkg;

    // Serial-flash instruction opcodes
    localparam logic [7:0] OP_READ         = 8'h03;
    localparam logic [7:0] OP_FAST_READ    = 8'h0B;
    localparam logic [7:0] OP_PAGE_PROG    = 8'h02;
    localparam logic [7:0] OP_WRITE_ENABLE = 8'h06;
    localparam logic [7:0] OP_READ_STATUS  = 8'h05;
    localparam logic [7:0] OP_SECTOR_ERASE = 8'h20;

    // Host command encoding on cmd_op
    typedef enum logic [1:0] {
        CMD_READ     = 2'd0,
        CMD_PROGRAM  = 2'd1,
        CMD_ERASE    = 2'd2,
        CMD_RESERVED = 2'd3
    } cmd_op_e;

    // Sequencer states; the encoding is exported on state_out
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_FIN  = 4'd1,
        ST_RD_OA     = 4'd2,
        ST_RD_DATA   = 4'd3,
        ST_RD_FIN    = 4'd4,
        ST_WREN      = 4'd5,
        ST_WREN_FIN  = 4'd6,
        ST_PG_OA     = 4'd7,
        ST_PG_DATA   = 4'd8,
        ST_PG_FIN    = 4'd9,
        ST_ER_OA     = 4'd10,
        ST_ER_FIN    = 4'd11,
        ST_POLL_OA   = 4'd12,
        ST_POLL_DATA = 4'd13,
        ST_POLL_FIN  = 4'd14,
        ST_DONE      = 4'd15
    } state_e;

endpackage

// File: rtl/spi_seq_phase.sv
// Generic level handshake towards the SPI master: the trigger rises one cycle
// after i_start, stays high until i_complete is seen, then falls. A new start
// is only accepted once both trigger and completion are low again, so the
// trigger is always low for at least one cycle between phases.
module spi_seq_phase (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_complete,
    output logic o_trigger,
    output logic o_ready,
    output logic o_done
);

    logic r_trigger;

    // Trigger level: raise on start, release once the master reports completion
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_trigger <= 1'b0;
        end else if (r_trigger && i_complete) begin
            r_trigger <= 1'b0;
        end else if (!r_trigger && i_start && !i_complete) begin
            r_trigger <= 1'b1;
        end
    end

    assign o_trigger = r_trigger;
    assign o_ready   = !r_trigger && !i_complete;
    assign o_done    = r_trigger && i_complete;

endmodule

// File: rtl/spi_flash_sequencer.sv
// SPI flash command sequencer: turns host read / page-program / sector-erase
// commands into opcode/address, data and finalize phases for an SPI master,
// including write-enable and status polling.
// Optional build macro SPI_SEQ_FAST_READ_EN selects fast read (0x0B, 8 dummy
// cycles) instead of normal read (0x03, no dummy cycles).
module spi_flash_sequencer
    import spi_seq_pkg::*;
#(
    parameter int          ADDR_BYTES = 3,
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
    input  logic                    main_clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_BYTES*8-1:0] cmd_addr,
    input  logic [8:0]              cmd_len,
    input  logic [7:0]              wr_data,
    output logic                    wr_req,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    output logic                    done,
    output logic                    error,
    output logic [3:0]              state_out,
    output logic [7:0]              m_opcode,
    output logic [ADDR_BYTES*8-1:0] m_addr,
    output logic                    m_addr_flag,
    output logic [7:0]              m_dummy_cycles,
    output logic [7:0]              m_write_data,
    output logic                    m_opcode_addr_trigger,
    output logic                    m_data_trigger,
    output logic                    m_finalize_trigger,
    input  logic                    m_opcode_addr_completed,
    input  logic                    m_data_trigger_captured,
    input  logic                    m_data_completed,
    input  logic                    m_finalize_completed,
    input  logic [7:0]              m_read_data
);

    localparam int AW = ADDR_BYTES * 8;

`ifdef SPI_SEQ_FAST_READ_EN
    localparam logic [7:0] READ_OPCODE = OP_FAST_READ;
    localparam logic [7:0] READ_DUMMY  = 8'd8;
`else
    localparam logic [7:0] READ_OPCODE = OP_READ;
    localparam logic [7:0] READ_DUMMY  = 8'd0;
`endif

    state_e        r_state;
    state_e        w_next;
    cmd_op_e       r_op;
    logic [AW-1:0] r_addr;
    logic [8:0]    r_count;
    logic [15:0]   r_pollCount;
    logic [7:0]    r_status;
    logic          r_needFin;
    logic          r_error;
    logic [7:0]    r_rdData;
    logic          r_rdValid;
    logic [7:0]    r_opcode;
    logic [AW-1:0] r_mAddr;
    logic          r_addrFlag;
    logic [7:0]    r_dummy;
    logic [7:0]    r_writeData;
    logic          r_captured;

    logic       w_accept;
    logic       w_cmdBad;
    logic       w_timeout;
    logic       w_oaStart;
    logic       w_dataStart;
    logic       w_finStart;
    logic [7:0] w_oaOpcode;
    logic       w_oaAddrFlag;
    logic [7:0] w_oaDummy;
    logic       w_oaReady;
    logic       w_oaDone;
    logic       w_dataReady;
    logic       w_dataDone;
    logic       w_dataComplete;
    logic       w_finReady;
    logic       w_finDone;

    // A program byte only counts as transferred once the master has captured it
    assign w_dataComplete = m_data_completed &&
                            ((r_state != ST_PG_DATA) || r_captured || m_data_trigger_captured);

    spi_seq_phase u_oaPhase (
        .i_clk      (main_clock),
        .i_reset    (reset),
        .i_start    (w_oaStart),
        .i_complete (m_opcode_addr_completed),
        .o_trigger  (m_opcode_addr_trigger),
        .o_ready    (w_oaReady),
        .o_done     (w_oaDone)
    );

    spi_seq_phase u_dataPhase (
        .i_clk      (main_clock),
        .i_reset    (reset),
        .i_start    (w_dataStart),
        .i_complete (w_dataComplete),
        .o_trigger  (m_data_trigger),
        .o_ready    (w_dataReady),
        .o_done     (w_dataDone)
    );

    spi_seq_phase u_finPhase (
        .i_clk      (main_clock),
        .i_reset    (reset),
        .i_start    (w_finStart),
        .i_complete (m_finalize_completed),
        .o_trigger  (m_finalize_trigger),
        .o_ready    (w_finReady),
        .o_done     (w_finDone)
    );

    // Next-state logic and phase launches for every step of the three sequences
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_cmdBad     = 1'b0;
        w_timeout    = 1'b0;
        w_oaStart    = 1'b0;
        w_dataStart  = 1'b0;
        w_finStart   = 1'b0;
        w_oaOpcode   = 8'h00;
        w_oaAddrFlag = 1'b0;
        w_oaDummy    = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_cmdBad = (cmd_op == CMD_RESERVED) || (cmd_len == 9'd0);
                    if (w_cmdBad)                 w_next = ST_IDLE;
                    else if (r_needFin)           w_next = ST_INIT_FIN;
                    else if (cmd_op == CMD_READ)  w_next = ST_RD_OA;
                    else                          w_next = ST_WREN;
                end
            end
            ST_INIT_FIN: begin
                w_finStart = w_finReady;
                if (w_finDone) w_next = (r_op == CMD_READ) ? ST_RD_OA : ST_WREN;
            end
            ST_RD_OA: begin
                w_oaStart    = w_oaReady;
                w_oaOpcode   = READ_OPCODE;
                w_oaAddrFlag = 1'b1;
                w_oaDummy    = READ_DUMMY;
                if (w_oaDone) w_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                w_dataStart = w_dataReady;
                if (w_dataDone && (r_count == 9'd1)) w_next = ST_RD_FIN;
            end
            ST_RD_FIN: begin
                w_finStart = w_finReady;
                if (w_finDone) w_next = ST_DONE;
            end
            ST_WREN: begin
                w_oaStart  = w_oaReady;
                w_oaOpcode = OP_WRITE_ENABLE;
                if (w_oaDone) w_next = ST_WREN_FIN;
            end
            ST_WREN_FIN: begin
                w_finStart = w_finReady;
                if (w_finDone) w_next = (r_op == CMD_PROGRAM) ? ST_PG_OA : ST_ER_OA;
            end
            ST_PG_OA: begin
                w_oaStart    = w_oaReady;
                w_oaOpcode   = OP_PAGE_PROG;
                w_oaAddrFlag = 1'b1;
                if (w_oaDone) w_next = ST_PG_DATA;
            end
            ST_PG_DATA: begin
                w_dataStart = w_dataReady;
                if (w_dataDone && (r_count == 9'd1)) w_next = ST_PG_FIN;
            end
            ST_PG_FIN: begin
                w_finStart = w_finReady;
                if (w_finDone) w_next = ST_POLL_OA;
            end
            ST_ER_OA: begin
                w_oaStart    = w_oaReady;
                w_oaOpcode   = OP_SECTOR_ERASE;
                w_oaAddrFlag = 1'b1;
                if (w_oaDone) w_next = ST_ER_FIN;
            end
            ST_ER_FIN: begin
                w_finStart = w_finReady;
                if (w_finDone) w_next = ST_POLL_OA;
            end
            ST_POLL_OA: begin
                w_oaStart  = w_oaReady;
                w_oaOpcode = OP_READ_STATUS;
                if (w_oaDone) w_next = ST_POLL_DATA;
            end
            ST_POLL_DATA: begin
                w_dataStart = w_dataReady;
                if (w_dataDone) w_next = ST_POLL_FIN;
            end
            ST_POLL_FIN: begin
                w_finStart = w_finReady;
                if (w_finDone) begin
                    if (!r_status[0]) begin
                        w_next = ST_DONE;
                    end else if ((r_pollCount + 16'd1) >= POLL_LIMIT) begin
                        w_timeout = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_next = ST_POLL_OA;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, command latch, counters and master-side registered outputs
    always_ff @(posedge main_clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= CMD_READ;
            r_addr      <= '0;
            r_count     <= 9'd0;
            r_pollCount <= 16'd0;
            r_status    <= 8'h00;
            r_needFin   <= 1'b1;
            r_error     <= 1'b0;
            r_rdData    <= 8'h00;
            r_rdValid   <= 1'b0;
            r_opcode    <= 8'h00;
            r_mAddr     <= '0;
            r_addrFlag  <= 1'b0;
            r_dummy     <= 8'h00;
            r_writeData <= 8'h00;
        end else begin
            r_state   <= w_next;
            r_rdValid <= 1'b0;
            if (w_accept) begin
                if (w_cmdBad) begin
                    r_error <= 1'b1;
                end else begin
                    r_error     <= 1'b0;
                    r_op        <= cmd_op_e'(cmd_op);
                    r_addr      <= cmd_addr;
                    r_count     <= cmd_len;
                    r_pollCount <= 16'd0;
                end
            end
            if ((r_state == ST_INIT_FIN) && w_finDone) r_needFin <= 1'b0;
            if (w_oaStart) begin
                r_opcode   <= w_oaOpcode;
                r_addrFlag <= w_oaAddrFlag;
                r_dummy    <= w_oaDummy;
                r_mAddr    <= w_oaAddrFlag ? r_addr : '0;
            end
            if (wr_req) r_writeData <= wr_data;
            if (w_dataDone) begin
                if ((r_state == ST_RD_DATA) || (r_state == ST_PG_DATA)) r_count <= r_count - 9'd1;
                if (r_state == ST_RD_DATA) begin
                    r_rdData  <= m_read_data;
                    r_rdValid <= 1'b1;
                end
                if (r_state == ST_POLL_DATA) r_status <= m_read_data;
            end
            if ((r_state == ST_POLL_FIN) && w_finDone) r_pollCount <= r_pollCount + 16'd1;
            if (w_timeout) r_error <= 1'b1;
        end
    end

    // Remembers that the current program byte has been captured by the master
    always_ff @(posedge main_clock) begin
        if (reset || !m_data_trigger) r_captured <= 1'b0;
        else if (m_data_trigger_captured) r_captured <= 1'b1;
    end

    assign cmd_ready      = (r_state == ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign state_out      = r_state;
    assign wr_req         = w_dataStart && (r_state == ST_PG_DATA);
    assign rd_data        = r_rdData;
    assign rd_valid       = r_rdValid;
    assign error          = r_error;
    assign m_opcode       = r_opcode;
    assign m_addr         = r_mAddr;
    assign m_addr_flag    = r_addrFlag;
    assign m_dummy_cycles = r_dummy;
    assign m_write_data   = r_writeData;

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Self-checking bench for spi_flash_sequencer: a responsive SPI-master model
// logs every frame it sees, and a command-level flash model predicts frames,
// read bytes, done and error. Honours SPI_SEQ_FAST_READ_EN like the design.
module tb_spi_flash_sequencer;

   localparam logic [15:0] POLL_LIM = 16'd3;
`ifdef SPI_SEQ_FAST_READ_EN
   localparam logic [7:0] EXP_RD_OP    = 8'h0B;
   localparam logic [7:0] EXP_RD_DUMMY = 8'd8;
`else
   localparam logic [7:0] EXP_RD_OP    = 8'h03;
   localparam logic [7:0] EXP_RD_DUMMY = 8'd0;
`endif
   localparam logic [1:0] EV_OA = 2'd1, EV_DATA = 2'd2, EV_FIN = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  op;
      logic        flag;
      logic [23:0] addr;
      logic [7:0]  dummy;
      logic [7:0]  data;
   } ev_t;

   logic        main_clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [23:0] cmd_addr;
   logic [8:0]  cmd_len;
   logic [7:0]  wr_data;
   logic        wr_req;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        done;
   logic        error;
   logic [3:0]  state_out;
   logic [7:0]  m_opcode;
   logic [23:0] m_addr;
   logic        m_addr_flag;
   logic [7:0]  m_dummy_cycles;
   logic [7:0]  m_write_data;
   logic        m_opcode_addr_trigger;
   logic        m_data_trigger;
   logic        m_finalize_trigger;
   logic        m_opcode_addr_completed;
   logic        m_data_trigger_captured;
   logic        m_data_completed;
   logic        m_finalize_completed;
   logic [7:0]  m_read_data;

   int checks = 0;
   int failures = 0;

   ev_t        actEv[$];
   ev_t        expEv[$];
   logic [7:0] rdLog[$];
   logic [7:0] expRd[$];
   logic [7:0] wrBytes[$];
   logic [7:0] rdBytes[$];
   logic [7:0] statusSeq[$];
   logic [7:0] statusQ[$];
   logic [7:0] rdQ[$];
   int         doneCount, wrReqCount, violations, nData, wrIdx;
   int         expDone;
   logic       expErr;
   bit         tbNeedFin = 1'b1;

   spi_flash_sequencer #(.ADDR_BYTES(3), .POLL_LIMIT(POLL_LIM)) dut (
      .main_clock(main_clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .error(error), .state_out(state_out),
      .m_opcode(m_opcode), .m_addr(m_addr), .m_addr_flag(m_addr_flag),
      .m_dummy_cycles(m_dummy_cycles), .m_write_data(m_write_data),
      .m_opcode_addr_trigger(m_opcode_addr_trigger), .m_data_trigger(m_data_trigger),
      .m_finalize_trigger(m_finalize_trigger),
      .m_opcode_addr_completed(m_opcode_addr_completed),
      .m_data_trigger_captured(m_data_trigger_captured),
      .m_data_completed(m_data_completed), .m_finalize_completed(m_finalize_completed),
      .m_read_data(m_read_data)
   );

   // Free-running clock
   always #5 main_clock = ~main_clock;

   function automatic ev_t mkEv(input logic [1:0] k, input logic [7:0] o, input logic f,
                                input logic [23:0] a, input logic [7:0] d, input logic [7:0] v);
      ev_t e;
      e.kind = k; e.op = o; e.flag = f; e.addr = a; e.dummy = d; e.data = v;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // SPI master and host model: answers each handshake after a random delay,
   // logs frames, and feeds program bytes in show-ahead fashion
   initial begin : slaveModel
      int oaWait, dWait, fWait;
      logic [7:0] wdAtRise, wrExpect, v;
      bit wrPending;
      oaWait = 0; dWait = 0; fWait = 0; wrPending = 0; wdAtRise = 0; wrExpect = 0;
      m_opcode_addr_completed = 0; m_data_trigger_captured = 0;
      m_data_completed = 0; m_finalize_completed = 0; m_read_data = 0;
      forever begin
         @(posedge main_clock);
         #1;
         if (m_opcode_addr_trigger === 1'b1) begin
            if (!m_opcode_addr_completed) begin
               if (oaWait == 0) begin
                  m_opcode_addr_completed = 1;
                  actEv.push_back(mkEv(EV_OA, m_opcode, m_addr_flag,
                                       m_addr_flag ? m_addr : 24'h0, m_dummy_cycles, 8'h00));
               end else oaWait--;
            end
         end else begin
            m_opcode_addr_completed = 0;
            oaWait = $urandom_range(0, 2);
         end
         if (m_data_trigger === 1'b1) begin
            if (!m_data_trigger_captured) begin
               m_data_trigger_captured = 1;
               wdAtRise = m_write_data;
            end else begin
               if (m_write_data !== wdAtRise) violations++;
               if (!m_data_completed) begin
                  if (dWait == 0) begin
                     if (m_opcode == 8'h05) v = (statusQ.size() > 0) ? statusQ.pop_front() : 8'h01;
                     else if (m_opcode == 8'h02) v = m_write_data;
                     else v = (rdQ.size() > 0) ? rdQ.pop_front() : 8'h00;
                     if (m_opcode != 8'h02) m_read_data = v;
                     m_data_completed = 1;
                     nData++;
                     actEv.push_back(mkEv(EV_DATA, 8'h00, 1'b0, 24'h0, 8'h00, v));
                  end else dWait--;
               end
            end
         end else begin
            m_data_trigger_captured = 0;
            m_data_completed = 0;
            dWait = $urandom_range(0, 2);
         end
         if (m_finalize_trigger === 1'b1) begin
            if (!m_finalize_completed) begin
               if (fWait == 0) begin
                  m_finalize_completed = 1;
                  actEv.push_back(mkEv(EV_FIN, 8'h00, 1'b0, 24'h0, 8'h00, 8'h00));
               end else fWait--;
            end
         end else begin
            m_finalize_completed = 0;
            fWait = $urandom_range(0, 2);
         end
         #2;
         if (wrPending) begin
            if (!(m_data_trigger === 1'b1 && m_write_data === wrExpect)) violations++;
            wrPending = 0;
            wrIdx++;
            wr_data = (wrIdx < wrBytes.size()) ? wrBytes[wrIdx] : 8'h00;
         end
         if (wr_req === 1'b1) begin
            wrPending = 1;
            wrExpect = wr_data;
            wrReqCount++;
         end
         if (rd_valid === 1'b1) rdLog.push_back(rd_data);
         if (done === 1'b1) doneCount++;
      end
   end

   // Command-level flash model: predicts frames, read bytes, done and error
   task automatic buildExpected(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len);
      logic [7:0] s;
      expEv.delete(); expRd.delete(); expDone = 0; expErr = 0;
      if (op == 2'd3 || len == 9'd0) begin
         expErr = 1;
         return;
      end
      if (tbNeedFin) expEv.push_back(mkEv(EV_FIN, 0, 0, 0, 0, 0));
      if (op == 2'd0) begin
         expEv.push_back(mkEv(EV_OA, EXP_RD_OP, 1, addr, EXP_RD_DUMMY, 0));
         for (int i = 0; i < int'(len); i++) begin
            s = (i < rdBytes.size()) ? rdBytes[i] : 8'h00;
            expEv.push_back(mkEv(EV_DATA, 0, 0, 0, 0, s));
            expRd.push_back(s);
         end
         expEv.push_back(mkEv(EV_FIN, 0, 0, 0, 0, 0));
         expDone = 1;
         return;
      end
      expEv.push_back(mkEv(EV_OA, 8'h06, 0, 0, 0, 0));
      expEv.push_back(mkEv(EV_FIN, 0, 0, 0, 0, 0));
      expEv.push_back(mkEv(EV_OA, (op == 2'd1) ? 8'h02 : 8'h20, 1, addr, 0, 0));
      if (op == 2'd1)
         for (int i = 0; i < int'(len); i++) expEv.push_back(mkEv(EV_DATA, 0, 0, 0, 0, wrBytes[i]));
      expEv.push_back(mkEv(EV_FIN, 0, 0, 0, 0, 0));
      expErr = 1;
      for (int i = 0; i < int'(POLL_LIM); i++) begin
         s = (i < statusSeq.size()) ? statusSeq[i] : 8'h01;
         expEv.push_back(mkEv(EV_OA, 8'h05, 0, 0, 0, 0));
         expEv.push_back(mkEv(EV_DATA, 0, 0, 0, 0, s));
         expEv.push_back(mkEv(EV_FIN, 0, 0, 0, 0, 0));
         if (!s[0]) begin
            expErr = 0;
            expDone = 1;
            break;
         end
      end
   endtask

   task automatic issueOnly(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len);
      for (int c = 0; c < 200 && cmd_ready !== 1'b1; c++) begin
         @(posedge main_clock); #1;
      end
      cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
      @(posedge main_clock); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [23:0] addr, input logic [8:0] len,
                                input bit glitch);
      int c;
      issueOnly(op, addr, len);
      if (glitch) begin
         repeat (3) @(posedge main_clock);
         #1;
         cmd_op = 2'd0; cmd_len = 9'd0; cmd_valid = 1'b1;
         @(posedge main_clock); #1;
         cmd_valid = 1'b0;
      end
      for (c = 0; c < 8000 && cmd_ready !== 1'b1; c++) begin
         @(posedge main_clock); #1;
      end
      if (c >= 8000) checkOutput("cmdTimeout", {63'b0, cmd_ready}, 64'd1);
      repeat (2) @(posedge main_clock);
      #1;
   endtask

   task automatic runCommand(input string tag, input logic [1:0] op, input logic [23:0] addr,
                             input logic [8:0] len, input bit glitch);
      actEv.delete(); rdLog.delete();
      doneCount = 0; wrReqCount = 0; violations = 0; nData = 0; wrIdx = 0;
      statusQ = statusSeq; rdQ = rdBytes;
      wr_data = (wrBytes.size() > 0) ? wrBytes[0] : 8'h00;
      buildExpected(op, addr, len);
      applyStimulus(op, addr, len, glitch);
      checkOutput({tag, ".error"}, {63'b0, error}, {63'b0, expErr});
      checkOutput({tag, ".done"}, 64'(doneCount), 64'(expDone));
      checkOutput({tag, ".ready"}, {63'b0, cmd_ready}, 64'd1);
      checkOutput({tag, ".frames"}, 64'(actEv.size()), 64'(expEv.size()));
      for (int i = 0; i < actEv.size() && i < expEv.size(); i++)
         checkOutput($sformatf("%s.ev%0d", tag, i), 64'(actEv[i]), 64'(expEv[i]));
      checkOutput({tag, ".rdCount"}, 64'(rdLog.size()), 64'(expRd.size()));
      for (int i = 0; i < rdLog.size() && i < expRd.size(); i++)
         checkOutput($sformatf("%s.rd%0d", tag, i), 64'(rdLog[i]), 64'(expRd[i]));
      checkOutput({tag, ".wrReq"}, 64'(wrReqCount), (op == 2'd1 && !(len == 0)) ? 64'(len) : 64'd0);
      checkOutput({tag, ".wrStable"}, 64'(violations), 64'd0);
      if (!(op == 2'd3 || len == 9'd0)) tbNeedFin = 1'b0;
   endtask

   // Hard stop in case something wedges the bench itself
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog observed=stuck expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed and randomized command sequence
   initial begin : stimulus
      logic [1:0] rop;
      logic [8:0] rlen;
      int busy;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 24'h0; cmd_len = 9'd0; wr_data = 8'h00;
      repeat (2) @(posedge main_clock);
      #1;
      checkOutput("rst.triggers", {61'b0, m_opcode_addr_trigger, m_data_trigger, m_finalize_trigger}, 64'd0);
      checkOutput("rst.state", 64'(state_out), 64'd0);
      checkOutput("rst.flags", {60'b0, wr_req, rd_valid, done, error}, 64'd0);
      checkOutput("rst.rdData", 64'(rd_data), 64'd0);
      checkOutput("rst.opcode", 64'(m_opcode), 64'd0);
      checkOutput("rst.addr", 64'(m_addr), 64'd0);
      checkOutput("rst.wdata", 64'(m_write_data), 64'd0);
      checkOutput("rst.dummy", 64'(m_dummy_cycles), 64'd0);
      reset = 1'b0;
      @(posedge main_clock); #1;
      checkOutput("rst.ready", {63'b0, cmd_ready}, 64'd1);

      rdBytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      runCommand("read4", 2'd0, 24'h012345, 9'd4, 1'b0);

      wrBytes = '{8'h55, 8'hAA};
      statusSeq = '{8'h01, 8'h01, 8'h00};
      runCommand("prog2", 2'd1, 24'h000100, 9'd2, 1'b1);

      statusSeq.delete();
      runCommand("eraseTimeout", 2'd2, 24'h040000, 9'd1, 1'b0);

      runCommand("lenZero", 2'd0, 24'h000010, 9'd0, 1'b0);
      runCommand("opReserved", 2'd3, 24'h000010, 9'd4, 1'b0);

      for (int n = 0; n < 12; n++) begin
         rop = 2'($urandom_range(0, 2));
         rlen = 9'($urandom_range(1, 8));
         busy = $urandom_range(0, 3);
         rdBytes.delete(); wrBytes.delete(); statusSeq.delete();
         for (int i = 0; i < int'(rlen); i++) begin
            rdBytes.push_back(8'($urandom));
            wrBytes.push_back(8'($urandom));
         end
         for (int i = 0; i < busy; i++) statusSeq.push_back(8'($urandom) | 8'h01);
         statusSeq.push_back(8'($urandom) & 8'hFE);
         runCommand($sformatf("rand%0d", n), rop, 24'($urandom), rlen, 1'b0);
      end

      rdBytes.delete();
      for (int i = 0; i < 256; i++) rdBytes.push_back(8'($urandom));
      runCommand("read256", 2'd0, 24'hFFFF00, 9'd256, 1'b0);

      // Reset while the second read byte is in flight
      rdBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      rdQ = rdBytes; nData = 0;
      issueOnly(2'd0, 24'h000200, 9'd6);
      for (int c = 0; c < 2000; c++) begin
         @(posedge main_clock); #2;
         if (nData >= 1 && m_data_trigger === 1'b1) break;
      end
      checkOutput("midRst.inByte2", {63'b0, m_data_trigger}, 64'd1);
      reset = 1'b1;
      @(posedge main_clock); #1;
      checkOutput("midRst.triggers", {61'b0, m_opcode_addr_trigger, m_data_trigger, m_finalize_trigger}, 64'd0);
      checkOutput("midRst.state", 64'(state_out), 64'd0);
      @(posedge main_clock); #1;
      reset = 1'b0;
      tbNeedFin = 1'b1;
      @(posedge main_clock); #1;
      rdBytes = '{8'hC1, 8'hC2, 8'hC3};
      runCommand("postRst", 2'd0, 24'h000300, 9'd3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_flash_sequencer.md
SPI_FLASH_SEQUENCER -- requirements
Module: spi_flash_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_BYTES, default 3, address width in bytes; POLL_LIMIT, default 16'hFFFF, maximum status-register reads before timeout.
REQ-002 Clock and reset SHALL be: main_clock in 1, sole clock, all logic on rising edge; reset in 1, synchronous, active-high.
REQ-003 Command ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_op in 2 (0 read, 1 page program, 2 sector erase, 3 reserved); cmd_addr in ADDR_BYTES*8; cmd_len in 9 (data byte count, 1..256).
REQ-004 Data ports SHALL be: wr_data in 8, program byte; wr_req out 1, one-cycle pulse, wr_data sampled on the next cycle; rd_data out 8; rd_valid out 1, one-cycle pulse.
REQ-005 Status ports SHALL be: done out 1, one-cycle pulse; error out 1, sticky; state_out out 4.
REQ-006 Master-side outputs SHALL be: m_opcode 8; m_addr ADDR_BYTES*8; m_addr_flag 1; m_dummy_cycles 8; m_write_data 8; m_opcode_addr_trigger 1; m_data_trigger 1; m_finalize_trigger 1.
REQ-007 Master-side inputs SHALL be: m_opcode_addr_completed 1; m_data_trigger_captured 1; m_data_completed 1; m_finalize_completed 1; m_read_data 8.

Function
REQ-008 A command SHALL be accepted on the cycle where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 1 only in IDLE, and cmd_op 3 or cmd_len 0 SHALL set error and return to IDLE.
REQ-009 Each master phase SHALL use a level handshake: raise the trigger, hold it until the matching completion/captured input is 1, then drop it for at least one cycle before the next trigger.
REQ-010 A frame SHALL be: opcode/address phase, N data phases, then finalize (hold m_finalize_trigger until m_finalize_completed is 1, then release).
REQ-011 Read sequence SHALL be IDLE -> RD_OA (opcode 0x03, addr_flag 1, dummy 0) -> RD_DATA x cmd_len -> RD_FIN -> DONE.
REQ-012 In RD_DATA, each m_data_completed rising edge SHALL register m_read_data into rd_data and pulse rd_valid.
REQ-013 Program sequence SHALL be WREN (0x06, no address, no data) -> WREN_FIN -> PG_OA (0x02, addr_flag 1) -> PG_DATA x cmd_len -> PG_FIN -> POLL.
REQ-014 In PG_DATA, wr_req SHALL pulse one cycle before each m_data_trigger rise, and m_write_data SHALL be held stable until m_data_trigger_captured is 1.
REQ-015 Erase sequence SHALL be WREN -> WREN_FIN -> ER_OA (0x20, addr_flag 1, zero data phases) -> ER_FIN -> POLL.
REQ-016 POLL SHALL issue 0x05 (no address) with one data phase per frame, repeating until m_read_data[0] is 0; it SHALL then enter DONE.
REQ-017 A 16-bit poll counter SHALL count frames; reaching POLL_LIMIT SHALL set error, finalize, and return to IDLE without pulsing done.
REQ-018 DONE SHALL pulse done for one cycle and return to IDLE; the byte counter SHALL be 9 bits, decrement per data phase, and end the phase at 0.
REQ-019 cmd_valid SHALL be ignored outside IDLE; error SHALL clear only on the next accepted command or on reset.

Reset
REQ-020 Reset SHALL force IDLE; all triggers, wr_req, rd_valid, done, error = 0; rd_data, m_opcode, m_addr, m_write_data = 0; m_dummy_cycles = 0; counters = 0.
REQ-021 Reset mid-frame SHALL drop all triggers in the same cycle; the first post-reset command SHALL first issue a finalize-only handshake to release chip select.

Configuration
REQ-022 With SPI_SEQ_FAST_READ_EN defined, RD_OA SHALL use opcode 0x0B with m_dummy_cycles 8; without it, RD_OA SHALL use 0x03 with m_dummy_cycles 0, and no other behaviour SHALL differ.

Structure
REQ-023 Package spi_seq_pkg SHALL hold opcode constants (0x03, 0x0B, 0x02, 0x06, 0x05, 0x20), the cmd_op encoding, and the state enumeration.
REQ-024 One sub-module, spi_seq_phase, SHALL implement the generic trigger/complete handshake of REQ-009 and be reused for all three phases.

Verification
REQ-025 Read, addr 0x012345, len 4, slave returns A0..A3 -> opcode 0x03, addr_flag 1, four rd_valid pulses carrying A0..A3, one done pulse.
REQ-026 Program, addr 0x000100, len 2, data 55 AA -> WREN frame, then 0x02 frame with two wr_req pulses and write bytes 55, AA; status reads 0x01, 0x01, 0x00 -> three poll frames, then done.
REQ-027 Erase with POLL_LIMIT 3, status fixed at 0x01 -> exactly 3 poll frames, error 1, done never pulses, cmd_ready returns to 1.
REQ-028 Reset asserted during RD_DATA byte 2 -> all triggers 0 on the next cycle; the next command begins with a finalize-only handshake.
REQ-029 cmd_len 256 read -> exactly 256 rd_valid pulses; cmd_len 0 -> error 1, no trigger raised.
REQ-030 Build with SPI_SEQ_FAST_READ_EN defined -> opcode 0x0B, m_dummy_cycles 8; build without it -> opcode 0x03, m_dummy_cycles 0.
